mod_add_sequencer: RTL and testbench
====================================

Name: mod_add_sequencer

Overview:
Upstream issue/capture stage for the combinational modulo-(2^W − k) adder chain: preprocessing, parallel prefix, then sum computation.
- Accepts operand triples (a, b, k) over a valid/ready handshake.
- Drives them stably into the adder for a programmable settle window, then captures the sum.
- Returns the sum over a second valid/ready handshake.
- Replaces the fixed-delay operand driving used in the top-level bench and lets the adder run inside a clocked system.

Parameters:
- W, 7, operand/sum width (matches adder vector width)
- SETTLE_CYCLES, 2, cycles operands are held on the adder before the sum is captured; legal range 1..15

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand triple valid
- in_ready  out  1  sequencer can accept operands
- in_a  in  W  operand a
- in_b  in  W  operand b
- in_k  in  W  modulo controller k
- add_a  out  W  registered a to adder preprocessing stage
- add_b  out  W  registered b to adder preprocessing stage
- add_k  out  W  registered k to adder preprocessing stage
- add_sum  in  W  sum_vector from adder sum computation stage
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_sum  out  W  captured sum
- busy  out  1  high in SETTLE or HOLD
- txn_count  out  16  completed result handshakes, wraps 0xFFFF→0

Behaviour:
- **Reset** (rst high at clk edge): state=IDLE; add_a/add_b/add_k=0; out_sum=0; out_valid=0; txn_count=0; settle counter=0. Reset mid-SETTLE or mid-HOLD discards the transaction with no output. rst overrides all handshakes in the same cycle.
- **FSM states:** IDLE, SETTLE, HOLD.
- **IDLE:**
  - in_ready=1.
  - On in_valid: register in_a/in_b/in_k into add_a/add_b/add_k, load cnt=SETTLE_CYCLES−1, go SETTLE.
- **SETTLE:**
  - in_ready=0; add_* held constant.
  - If cnt==0: capture add_sum into out_sum, set out_valid=1, go HOLD.
  - Otherwise cnt decrements.
- **HOLD:**
  - out_valid=1; out_sum and add_* held stable while out_ready=0, for an unbounded time.
  - in_ready=out_ready (combinational passthrough; the only combinational in→out path).
  - out_ready=1 and in_valid=0: out_valid→0, txn_count+1, go IDLE.
  - out_ready=1 and in_valid=1 in the same cycle: result retires, new operands are accepted, cnt reloaded, go SETTLE (back-to-back, no IDLE bubble).
- **Latency:** accept at edge t → out_valid high after edge t+SETTLE_CYCLES.
- **Throughput:** sustained one result per SETTLE_CYCLES+1 cycles.
- **Widths:** add_sum is captured unmodified; no arithmetic on the data path. The settle counter is 4 bits.
- **Input rules:**
  - in_* are ignored when in_ready=0.
  - in_valid is not required to stay high once asserted (no X propagation onto add_*).

Optional Feature:
MOD_ADD_SEQ_SELFCHECK_EN
- **Defined:**
  - Adds output port `mismatch` (1 bit, sticky, cleared only by rst).
  - At the capture edge, computes M=2^W−k (W+1 bits) and s=a+b (W+1 bits); ref = s≥M ? s−M : s.
  - Sets `mismatch` if add_sum≠ref[W−1:0].
  - The check is suppressed when a≥M or b≥M.
  - Zero effect on timing of the handshake outputs.
- **Not defined:** no port, no logic.

Decomposition:
- Shared package mod_add_pkg holds:
  - State enum typedef (IDLE/SETTLE/HOLD).
  - Default width constant W=7.
  - Settle-counter width constant (4).
- Natural sub-module: mod_add_ref_check, the combinational reference model behind MOD_ADD_SEQ_SELFCHECK_EN, reusable by the testbench scoreboard.
- FSM, counter and registers stay in mod_add_sequencer.

Test Plan (W=7, SETTLE_CYCLES=2, real adder chain attached):
- a=10, b=20, k=64, out_ready=1 → out_valid after 2 edges, out_sum=30, txn_count=1, mismatch=0.
- a=50, b=30, k=64 (M=64) → out_sum=16; k=0 (M=128), a=100, b=50 → out_sum=22.
- Backpressure: out_ready=0 for 5 cycles in HOLD → out_valid=1, out_sum and add_* constant, in_ready=0; release → one retire, txn_count increments once.
- Back-to-back: in_valid and out_ready held high, 4 triples → 4 results spaced exactly 3 cycles apart, no IDLE state visited between them.
- Reset asserted in second SETTLE cycle → next edge: out_valid=0, add_*=0, state IDLE, txn_count=0, no result emitted.
- Self-check build with add_sum bit 0 forced inverted → mismatch=1 after first capture and remains set until rst.

Source files
------------

// File: rtl/mod_add_pkg.sv
// Shared definitions for the modulo-(2^W - k) adder sequencer slice.
//   state_t      : sequencer FSM states (IDLE / SETTLE / HOLD)
//   MOD_ADD_W    : default operand/sum width, matches the adder vector width
//   SETTLE_CNT_W : width of the settle-window down-counter
package mod_add_pkg;

  localparam int unsigned MOD_ADD_W    = 7;
  localparam int unsigned SETTLE_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

endpackage

// File: rtl/mod_add_ref_check.sv
// Combinational reference model of the modulo-(2^W - k) adder.
// Compiled only when MOD_ADD_SEQ_SELFCHECK_EN is defined.
// Ports:
//   a, b, k  : operands and modulo controller (W bits)
//   sum      : sum presented by the real adder chain (W bits)
//   check_en : both operands lie inside the modulus (a < M, b < M)
//   mismatch : check_en and sum differs from the reference
`ifdef MOD_ADD_SEQ_SELFCHECK_EN
module mod_add_ref_check
  import mod_add_pkg::*;
#(
  parameter int unsigned W = MOD_ADD_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] k,
  input  logic [W-1:0] sum,
  output logic         check_en,
  output logic         mismatch
);

  logic [W:0]   m;
  logic [W:0]   s;
  logic [W-1:0] ref_sum;

  always_comb begin
    // M = 2^W - k; k = 0 gives the full 2^W modulus, hence the W+1 bits.
    m        = {1'b1, {W{1'b0}}} - {1'b0, k};
    s        = {1'b0, a} + {1'b0, b};
    ref_sum  = (s >= m) ? W'(s - m) : W'(s);
    check_en = ({1'b0, a} < m) && ({1'b0, b} < m);
    mismatch = check_en && (sum != ref_sum);
  end

endmodule
`endif

// File: rtl/mod_add_sequencer.sv
// Issue/capture stage for the combinational modulo-(2^W - k) adder chain.
// Accepts (a, b, k) over in_valid/in_ready, holds them on add_a/b/k for
// SETTLE_CYCLES clocks, captures add_sum and returns it over
// out_valid/out_ready. A retire and a new accept may share one edge.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : operand handshake (in_ready = out_ready in HOLD)
//   in_a, in_b, in_k      : operands
//   add_a, add_b, add_k   : registered operands driven to the adder
//   add_sum               : sum from the adder
//   out_valid/out_ready   : result handshake
//   out_sum               : captured sum
//   busy                  : high in SETTLE or HOLD
//   txn_count             : completed result handshakes (wraps)
//   mismatch              : sticky self-check flag (MOD_ADD_SEQ_SELFCHECK_EN only)
// Optional feature macro: MOD_ADD_SEQ_SELFCHECK_EN.
module mod_add_sequencer
  import mod_add_pkg::*;
#(
  parameter int unsigned W             = MOD_ADD_W,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [W-1:0] in_k,
  output logic [W-1:0] add_a,
  output logic [W-1:0] add_b,
  output logic [W-1:0] add_k,
  input  logic [W-1:0] add_sum,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         busy,
`ifdef MOD_ADD_SEQ_SELFCHECK_EN
  output logic         mismatch,
`endif
  output logic [15:0]  txn_count
);

  localparam logic [SETTLE_CNT_W-1:0] CNT_LOAD = SETTLE_CNT_W'(SETTLE_CYCLES - 1);

  state_t                  state_q, state_d;
  logic [SETTLE_CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]            add_a_q, add_a_d;
  logic [W-1:0]            add_b_q, add_b_d;
  logic [W-1:0]            add_k_q, add_k_d;
  logic [W-1:0]            out_sum_q, out_sum_d;
  logic                    out_valid_q, out_valid_d;
  logic [15:0]             txn_count_q, txn_count_d;
  logic                    capture;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_k_d     = add_k_q;
    out_sum_d   = out_sum_q;
    out_valid_d = out_valid_q;
    txn_count_d = txn_count_q;
    in_ready    = 1'b0;
    capture     = 1'b0;

    unique case (state_q)
      ST_IDLE: in_ready = 1'b1;
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          capture     = 1'b1;
          out_sum_d   = add_sum;
          out_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end else begin
          cnt_d = cnt_q - SETTLE_CNT_W'(1);
        end
      end
      ST_HOLD: begin
        in_ready = out_ready;
        if (out_ready) begin
          out_valid_d = 1'b0;
          txn_count_d = txn_count_q + 16'd1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Accept path shared by IDLE and HOLD: in HOLD it overrides the
    // IDLE transition above, giving back-to-back issue with no bubble.
    if (in_valid && in_ready) begin
      add_a_d = in_a;
      add_b_d = in_b;
      add_k_d = in_k;
      cnt_d   = CNT_LOAD;
      state_d = ST_SETTLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_k_q     <= '0;
      out_sum_q   <= '0;
      out_valid_q <= 1'b0;
      txn_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_k_q     <= add_k_d;
      out_sum_q   <= out_sum_d;
      out_valid_q <= out_valid_d;
      txn_count_q <= txn_count_d;
    end
  end

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_k     = add_k_q;
  assign out_sum   = out_sum_q;
  assign out_valid = out_valid_q;
  assign txn_count = txn_count_q;
  assign busy      = (state_q != ST_IDLE);

`ifdef MOD_ADD_SEQ_SELFCHECK_EN
  logic mismatch_q, mismatch_d;
  logic ref_check_en;
  logic ref_mismatch;

  mod_add_ref_check #(.W(W)) u_ref_check (
    .a        (add_a_q),
    .b        (add_b_q),
    .k        (add_k_q),
    .sum      (add_sum),
    .check_en (ref_check_en),
    .mismatch (ref_mismatch)
  );

  always_comb begin
    mismatch_d = mismatch_q;
    if (capture && ref_check_en && ref_mismatch) mismatch_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) mismatch_q <= 1'b0;
    else     mismatch_q <= mismatch_d;
  end

  assign mismatch = mismatch_q;
`else
  logic unused_capture;
  assign unused_capture = capture;
`endif

endmodule

// File: tb/tb_mod_add_sequencer.sv
module tb_mod_add_sequencer;

  localparam int unsigned W  = 7;
  localparam int unsigned SC = 2;

  logic         clk       = 1'b0;
  logic         rst       = 1'b1;
  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] in_a      = '0;
  logic [W-1:0] in_b      = '0;
  logic [W-1:0] in_k      = '0;
  logic         in_ready, out_valid, busy;
  logic [W-1:0] add_a, add_b, add_k, add_sum, out_sum;
  logic [15:0]  txn_count;
  logic         corrupt = 1'b0;
`ifdef MOD_ADD_SEQ_SELFCHECK_EN
  logic         mismatch;
`endif

  always #5 clk = ~clk;

  // Behavioural modulo-(2^W - k) arithmetic.
  function automatic logic [W-1:0] mod_ref(logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] k);
    int m, s;
    m = (1 << W) - int'(k);
    s = int'(a) + int'(b);
    if (s >= m) s = s - m;
    return W'(s);
  endfunction

  function automatic bit in_domain(logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] k);
    int m;
    m = (1 << W) - int'(k);
    return (int'(a) < m) && (int'(b) < m);
  endfunction

  // Stand-in for the adder chain (optionally with bit 0 inverted).
  assign add_sum = mod_ref(add_a, add_b, add_k) ^ W'(corrupt);

  mod_add_sequencer #(.W(W), .SETTLE_CYCLES(SC)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_k      (in_k),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_k     (add_k),
    .add_sum   (add_sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .busy      (busy),
`ifdef MOD_ADD_SEQ_SELFCHECK_EN
    .mismatch  (mismatch),
`endif
    .txn_count (txn_count)
  );

  typedef struct {
    logic [W-1:0] a, b, k, sum;
    int           first;
    bit           bad;
  } exp_t;

  exp_t         sb[$];
  int           vectors     = 0;
  int           miscompares = 0;
  int           cyc         = 0;
  bit           chk_en      = 0;
  bit           rnd_or      = 0;
  logic [W-1:0] m_a = '0, m_b = '0, m_k = '0, m_sum = '0;
  logic [15:0]  m_txn = '0;
  bit           m_mm = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard: checks every output each cycle against the model,
  // then advances the model by the handshakes that the coming edge performs.
  always @(negedge clk) begin
    bit   ev, eir;
    exp_t e;
    if (chk_en) begin
      ev  = (sb.size() > 0) && (cyc >= sb[0].first);
      eir = (sb.size() == 0) || (ev && out_ready);
      chk("out_valid", 32'(out_valid), 32'(ev));
      chk("busy", 32'(busy), 32'(sb.size() > 0));
      chk("in_ready", 32'(in_ready), 32'(eir));
      chk("txn_count", 32'(txn_count), 32'(m_txn));
      chk("add_a", 32'(add_a), 32'(m_a));
      chk("add_b", 32'(add_b), 32'(m_b));
      chk("add_k", 32'(add_k), 32'(m_k));
      chk("out_sum", 32'(out_sum), 32'(m_sum));
`ifdef MOD_ADD_SEQ_SELFCHECK_EN
      chk("mismatch", 32'(mismatch), 32'(m_mm));
`endif
      if (rst) begin
        sb.delete();
        m_a = '0; m_b = '0; m_k = '0; m_sum = '0; m_txn = '0; m_mm = 0;
      end else begin
        if (ev && out_ready) begin
          void'(sb.pop_front());
          m_txn = m_txn + 16'd1;
        end
        if (in_valid && eir) begin
          e.a     = in_a;
          e.b     = in_b;
          e.k     = in_k;
          e.sum   = mod_ref(in_a, in_b, in_k) ^ W'(corrupt);
          e.bad   = corrupt && in_domain(in_a, in_b, in_k);
          e.first = cyc + 1 + int'(SC);
          sb.push_back(e);
          m_a = in_a; m_b = in_b; m_k = in_k;
        end
        if (sb.size() > 0 && cyc + 1 == sb[0].first) begin
          m_sum = sb[0].sum;
          if (sb[0].bad) m_mm = 1;
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_or) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Presents one triple; returns 1 time unit after the accepting edge.
  task automatic send(logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] k);
    int n;
    in_a = a; in_b = b; in_k = k;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout: in_ready low for %0d cycles, expected accept", n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = W'($urandom); in_b = W'($urandom); in_k = W'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || out_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      vectors++; miscompares++;
      $display("FAIL idle_timeout: still busy after %0d cycles, expected idle", n);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int prev, gap;
    @(posedge clk);
    #1 chk_en = 1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Directed sums
    send(7'd10, 7'd20, 7'd64);  wait_idle();
    send(7'd50, 7'd30, 7'd64);  wait_idle();
    send(7'd100, 7'd50, 7'd0);  wait_idle();

    // Backpressure held in HOLD
    out_ready = 1'b0;
    send(7'd33, 7'd44, 7'd5);
    repeat (8) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_idle();

    // Back-to-back issue with results spaced SC+1 cycles
    send(7'd1, 7'd2, 7'd3);
    prev = cyc;
    send(7'd60, 7'd60, 7'd10);
    chk("b2b_spacing", 32'(cyc - prev), 32'(SC + 1)); prev = cyc;
    send(7'd120, 7'd7, 7'd8);
    chk("b2b_spacing", 32'(cyc - prev), 32'(SC + 1)); prev = cyc;
    send(7'd0, 7'd0, 7'd127);
    chk("b2b_spacing", 32'(cyc - prev), 32'(SC + 1));
    wait_idle();

    // Reset in the second SETTLE cycle discards the transaction
    send(7'd5, 7'd6, 7'd7);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Random operands, random gaps, random backpressure
    rnd_or = 1;
    repeat (40) begin
      send(W'($urandom), W'($urandom), W'($urandom));
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
    rnd_or = 0;
    out_ready = 1'b1;
    wait_idle();

`ifdef MOD_ADD_SEQ_SELFCHECK_EN
    corrupt = 1'b1;
    send(7'd10, 7'd20, 7'd64);
    wait_idle();
    repeat (3) @(posedge clk);
    #1 corrupt = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
